solver_sequencer: RTL and testbench

- Top-level control FSM for the MCMC constraints solver.
- Loads the initial boolean/integer assignments into solver storage, then checks constraints.
- On each iteration it selects the next variable, launches the probabilistic search engine, commits its proposal to storage and re-checks constraints.
- Ends on a satisfying assignment, on iteration-budget exhaustion, or on a handshake watchdog timeout.

---
 rtl/solver_pkg.sv | 31 +++
 rtl/solver_watchdog.sv | 27 ++
 rtl/solver_sequencer.sv | 179 +++++++++++++++++
 tb/tb_solver_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/solver_pkg.sv
// Shared solver definitions: problem-size defaults, widths and sequencer state encoding.
package solver_pkg;

  localparam int NUM_BOOL_DEF = 4;
  localparam int NUM_INT_DEF  = 4;
  localparam int ITER_W_DEF   = 16;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL_REQ,
    ST_EVAL_WAIT,
    ST_PICK,
    ST_SEARCH_REQ,
    ST_SEARCH_WAIT,
    ST_COMMIT,
    ST_DONE,
    ST_FAIL
  } state_e;

  // A single variable still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wd_width(input int t);
    return (t > 1) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/solver_watchdog.sv
// Loadable down-counter used to bound handshake waits; expired while the count sits at zero.
module solver_watchdog #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/solver_sequencer.sv
// Top-level control FSM of the MCMC constraints solver: load, evaluate, pick, search, commit.
module solver_sequencer
  import solver_pkg::*;
#(
  parameter int NUMBER_OF_BOOLEAN_VARIABLES = NUM_BOOL_DEF,
  parameter int NUMBER_OF_INTEGER_VARIABLES = NUM_INT_DEF,
  parameter int ITER_W                      = ITER_W_DEF,
  parameter int TIMEOUT_CYCLES              = TIMEOUT_DEF,
  parameter int IDX_W = idx_width(NUMBER_OF_BOOLEAN_VARIABLES + NUMBER_OF_INTEGER_VARIABLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_start,
  input  logic [ITER_W-1:0] in_max_iterations,
  output logic              out_assignment_selector,
  output logic              out_load_storage,
  output logic [IDX_W-1:0]  out_var_index,
  output logic              out_var_is_integer,
  output logic              out_search_start,
  input  logic              in_search_done,
  output logic              out_eval_start,
  input  logic              in_eval_done,
  input  logic              in_all_satisfied,
  output logic              out_busy,
  output logic              out_solution_valid,
  output logic              out_fail,
  output logic              out_timeout,
  output logic [ITER_W-1:0] out_iteration_count
);

  localparam int NUM_VARS = NUMBER_OF_BOOLEAN_VARIABLES + NUMBER_OF_INTEGER_VARIABLES;
  localparam int WD_W     = wd_width(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VARS - 1);
  localparam logic [IDX_W-1:0] FIRST_INT = IDX_W'(NUMBER_OF_BOOLEAN_VARIABLES);
  // The counter holds TIMEOUT-1 on the first wait cycle and hits zero on the last allowed one.
  localparam logic [WD_W-1:0]  WD_LOAD   = WD_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  logic [ITER_W-1:0] r_max;
  logic [ITER_W-1:0] r_iter;
  logic [IDX_W-1:0]  r_idx;
  logic              r_is_int;
  logic              r_first_pick;
  logic              r_sel;
  logic              r_load;
  logic              r_search_start;
  logic              r_eval_start;
  logic              r_busy;
  logic              r_valid;
  logic              r_fail;
  logic              r_timeout;

  logic [IDX_W-1:0]  w_next_idx;
  logic [ITER_W-1:0] w_iter_inc;
  logic              w_wd_clear;
  logic              w_wd_enable;
  logic              w_wd_expired;

  assign w_next_idx  = (r_first_pick || (r_idx == LAST_IDX)) ? '0 : r_idx + 1'b1;
  assign w_iter_inc  = (r_iter == '1) ? r_iter : r_iter + 1'b1;
  assign w_wd_clear  = (r_state == ST_EVAL_REQ) || (r_state == ST_SEARCH_REQ);
  assign w_wd_enable = (r_state == ST_EVAL_WAIT) || (r_state == ST_SEARCH_WAIT);

  solver_watchdog #(
    .CNT_W(WD_W)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_wd_clear),
    .i_load_value(WD_LOAD),
    .i_enable    (w_wd_enable),
    .o_expired   (w_wd_expired)
  );

  // Outputs are set on the transition into a state so they line up with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_max          <= '0;
      r_iter         <= '0;
      r_idx          <= '0;
      r_is_int       <= 1'b0;
      r_first_pick   <= 1'b0;
      r_sel          <= 1'b0;
      r_load         <= 1'b0;
      r_search_start <= 1'b0;
      r_eval_start   <= 1'b0;
      r_busy         <= 1'b0;
      r_valid        <= 1'b0;
      r_fail         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_load         <= 1'b0;
      r_search_start <= 1'b0;
      r_eval_start   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            r_state      <= ST_LOAD;
            r_max        <= in_max_iterations;
            r_iter       <= '0;
            r_idx        <= '0;
            r_is_int     <= 1'b0;
            r_first_pick <= 1'b1;
            r_valid      <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b1;
            r_sel        <= 1'b0;
            r_load       <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state      <= ST_EVAL_REQ;
          r_eval_start <= 1'b1;
        end
        ST_EVAL_REQ: r_state <= ST_EVAL_WAIT;
        ST_EVAL_WAIT: begin
          if (in_eval_done) begin
            if (in_all_satisfied) begin
              r_state <= ST_DONE;
              r_valid <= 1'b1;
            end else if (r_iter == r_max) begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_state      <= ST_PICK;
              r_idx        <= w_next_idx;
              r_is_int     <= (w_next_idx >= FIRST_INT);
              r_first_pick <= 1'b0;
            end
          end else if (w_wd_expired) begin
            r_state   <= ST_FAIL;
            r_fail    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        ST_PICK: begin
          r_state        <= ST_SEARCH_REQ;
          r_search_start <= 1'b1;
        end
        ST_SEARCH_REQ: r_state <= ST_SEARCH_WAIT;
        ST_SEARCH_WAIT: begin
          if (in_search_done) begin
            r_state <= ST_COMMIT;
            r_sel   <= 1'b1;
            r_load  <= 1'b1;
            r_iter  <= w_iter_inc;
          end else if (w_wd_expired) begin
            r_state   <= ST_FAIL;
            r_fail    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        ST_COMMIT: begin
          r_state      <= ST_EVAL_REQ;
          r_eval_start <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_assignment_selector = r_sel;
  assign out_load_storage        = r_load;
  assign out_var_index           = r_idx;
  assign out_var_is_integer      = r_is_int;
  assign out_search_start        = r_search_start;
  assign out_eval_start          = r_eval_start;
  assign out_busy                = r_busy;
  assign out_solution_valid      = r_valid;
  assign out_fail                = r_fail;
  assign out_timeout             = r_timeout;
  assign out_iteration_count     = r_iter;

endmodule

// File: tb/tb_solver_sequencer.sv
// Randomized scoreboard bench for solver_sequencer with behavioural evaluator/search responders.
module tb_solver_sequencer;

  localparam int NB     = 4;
  localparam int NI     = 4;
  localparam int NV     = NB + NI;
  localparam int ITER_W = 16;
  localparam int TMO    = 16;
  localparam int IDX_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_start = 1'b0;
  logic [ITER_W-1:0] in_max_iterations = '0;
  logic              in_search_done = 1'b0;
  logic              in_eval_done = 1'b0;
  logic              in_all_satisfied = 1'b0;
  logic              out_assignment_selector;
  logic              out_load_storage;
  logic [IDX_W-1:0]  out_var_index;
  logic              out_var_is_integer;
  logic              out_search_start;
  logic              out_eval_start;
  logic              out_busy;
  logic              out_solution_valid;
  logic              out_fail;
  logic              out_timeout;
  logic [ITER_W-1:0] out_iteration_count;

  solver_sequencer #(
    .NUMBER_OF_BOOLEAN_VARIABLES(NB),
    .NUMBER_OF_INTEGER_VARIABLES(NI),
    .ITER_W(ITER_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_start               (in_start),
    .in_max_iterations      (in_max_iterations),
    .out_assignment_selector(out_assignment_selector),
    .out_load_storage       (out_load_storage),
    .out_var_index          (out_var_index),
    .out_var_is_integer     (out_var_is_integer),
    .out_search_start       (out_search_start),
    .in_search_done         (in_search_done),
    .out_eval_start         (out_eval_start),
    .in_eval_done           (in_eval_done),
    .in_all_satisfied       (in_all_satisfied),
    .out_busy               (out_busy),
    .out_solution_valid     (out_solution_valid),
    .out_fail               (out_fail),
    .out_timeout            (out_timeout),
    .out_iteration_count    (out_iteration_count)
  );

  always #5 clk = ~clk;

  // kind: 0 initial load, 1 search launch, 2 commit, 3 end of run
  typedef struct {
    int kind;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  run_k = -1;
  int  run_h = -1;
  int  eval_num = 0;
  int  search_num = 0;
  int  cyc = 0;
  int  last_search_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic flag_error(input string name);
    n_errors++;
    $display("FAIL %s", name);
  endtask

  function automatic int pick_lat();
    return ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(1, 4));
  endfunction

  // Expected event stream for one run: budget b, first satisfying evaluation k (-1 never),
  // search launch h that never gets an answer (-1 none).
  task automatic model_run(input int b, input int k, input int h);
    ev_t e;
    int  it;
    bit  fin;
    e = '{0, 0, 0, 0, 0};
    exp_q.push_back(e);
    it  = 0;
    fin = 1'b0;
    while (!fin) begin
      if (it == k) begin
        e = '{3, 1, 0, 0, it}; exp_q.push_back(e); fin = 1'b1;
      end else if (it == b) begin
        e = '{3, 0, 1, 0, it}; exp_q.push_back(e); fin = 1'b1;
      end else begin
        e = '{1, it % NV, ((it % NV) >= NB) ? 1 : 0, 0, 0}; exp_q.push_back(e);
        if (it == h) begin
          e = '{3, 0, 1, 1, it}; exp_q.push_back(e); fin = 1'b1;
        end else begin
          e = '{2, it + 1, it % NV, 0, 0}; exp_q.push_back(e);
          it++;
        end
      end
    end
  endtask

  // Evaluator and search engine stand-ins, plus spurious done pulses.
  initial begin : responder
    int   ev_cnt;
    int   sr_cnt;
    logic ev_sat;
    ev_cnt = 0; sr_cnt = 0; ev_sat = 1'b0;
    forever begin
      @(negedge clk);
      in_eval_done     = 1'b0;
      in_search_done   = 1'b0;
      in_all_satisfied = 1'($urandom_range(0, 1));
      if (!rst_n) begin
        ev_cnt = 0; sr_cnt = 0;
      end
      if (ev_cnt > 0) begin
        ev_cnt--;
        if (ev_cnt == 0) begin in_eval_done = 1'b1; in_all_satisfied = ev_sat; end
      end
      if (sr_cnt > 0) begin
        sr_cnt--;
        if (sr_cnt == 0) in_search_done = 1'b1;
      end
      if (out_eval_start) begin
        ev_sat = (eval_num == run_k);
        eval_num++;
        ev_cnt = pick_lat();
        if ($urandom_range(0, 2) == 0) begin in_eval_done = 1'b1; in_all_satisfied = 1'b1; end
      end
      if (out_search_start) begin
        if (search_num != run_h) sr_cnt = pick_lat();
        search_num++;
        if ($urandom_range(0, 2) == 0) in_search_done = 1'b1;
      end
      if (!out_busy && $urandom_range(0, 3) == 0) begin
        in_eval_done = 1'b1; in_all_satisfied = 1'b1; in_search_done = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic pv;
    logic pf;
    bit   pend;
    ev_t  e;
    pv = 1'b0; pf = 1'b0; pend = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pv = 1'b0; pf = 1'b0; pend = 1'b0;
        continue;
      end
      if (pend) begin
        pend = 1'b0;
        chk("idle_after_end", 32'(out_busy), 0);
        chk("sticky_hold", 32'({out_solution_valid, out_fail}), 32'({pv, pf}));
      end
      if (out_load_storage) begin
        if (exp_q.size() == 0) flag_error("unexpected_load_storage");
        else begin
          e = exp_q.pop_front();
          chk("load_kind", out_assignment_selector ? 2 : 0, 32'(e.kind));
          if (e.kind == 0) begin
            chk("load_count", 32'(out_iteration_count), 0);
            chk("load_index", 32'(out_var_index), 0);
            chk("load_flags", 32'({out_solution_valid, out_fail, out_timeout}), 0);
            chk("load_busy", 32'(out_busy), 1);
          end else begin
            chk("commit_count", 32'(out_iteration_count), 32'(e.a));
            chk("commit_index", 32'(out_var_index), 32'(e.b));
          end
        end
      end
      if (out_search_start) begin
        last_search_cyc = cyc;
        if (exp_q.size() == 0) flag_error("unexpected_search_start");
        else begin
          e = exp_q.pop_front();
          chk("search_kind", 1, 32'(e.kind));
          chk("search_index", 32'(out_var_index), 32'(e.a));
          chk("search_is_int", 32'(out_var_is_integer), 32'(e.b));
        end
      end
      if ((out_solution_valid && !pv) || (out_fail && !pf)) begin
        if (exp_q.size() == 0) flag_error("unexpected_end");
        else begin
          e = exp_q.pop_front();
          chk("end_kind", 3, 32'(e.kind));
          chk("end_valid", 32'(out_solution_valid), 32'(e.a));
          chk("end_fail", 32'(out_fail), 32'(e.b));
          chk("end_timeout", 32'(out_timeout), 32'(e.c));
          chk("end_count", 32'(out_iteration_count), 32'(e.d));
          chk("end_busy", 32'(out_busy), 1);
          if (e.c != 0) chk("timeout_latency", 32'(cyc - last_search_cyc), TMO + 1);
        end
        pend = 1'b1;
      end
      pv = out_solution_valid;
      pf = out_fail;
    end
  end

  task automatic start_run(input int b, input int k, input int h);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    run_k = k; run_h = h; eval_num = 0; search_num = 0;
    model_run(b, k, h);
    in_start = 1'b1;
    in_max_iterations = ITER_W'(b);
    @(negedge clk);
    in_start = 1'b0;
    in_max_iterations = ITER_W'($urandom);
  endtask

  task automatic do_run(input int b, input int k, input int h);
    bit fin;
    start_run(b, k, h);
    fin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!out_busy) begin fin = 1'b1; break; end
      if ($urandom_range(0, 11) == 0) begin
        in_start = 1'b1;
        in_max_iterations = ITER_W'($urandom);
      end
      @(negedge clk);
      in_start = 1'b0;
    end
    if (!fin) flag_error("run_did_not_finish");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(out_busy), 0);
    chk({tag, "_load"}, 32'(out_load_storage), 0);
    chk({tag, "_sel"}, 32'(out_assignment_selector), 0);
    chk({tag, "_sstart"}, 32'(out_search_start), 0);
    chk({tag, "_estart"}, 32'(out_eval_start), 0);
    chk({tag, "_flags"}, 32'({out_solution_valid, out_fail, out_timeout}), 0);
    chk({tag, "_count"}, 32'(out_iteration_count), 0);
    chk({tag, "_index"}, 32'({out_var_index, out_var_is_integer}), 0);
  endtask

  initial begin : main
    int  b;
    int  k;
    int  h;
    bit  seen;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    do_run(10, 0, -1);
    do_run(10, 3, -1);
    do_run(9, -1, -1);
    do_run(0, -1, -1);
    do_run(10, -1, 0);
    do_run(5, 2, -1);

    for (int r = 0; r < 25; r++) begin
      b = int'($urandom_range(0, 12));
      k = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, b + 2));
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, b)) : -1;
      do_run(b, k, h);
    end

    // Reset while the search engine is stalled.
    start_run(10, -1, 3);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (search_num > 3) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) flag_error("reset_test_no_search");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_run(4, 1, -1);
    repeat (3) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
